// File: rtl/cpu_mc.sv
// rtl/cpu_mc.sv - multi-cycle CPU core: FETCH/DECODE/EXEC/WB sequencer, register file and ALU.
// Optional multiply (op 6) is enabled by defining CPU_MC_MUL_EN.
module cpu_mc #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 6,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_valid,
  input  logic [31:0]       imem_rdata,
  output logic [DATA_W-1:0] out,
  output logic [PC_W-1:0]   pc_out,
  output logic              zero,
  output logic              halted,
  output logic              illegal
);

  localparam int RI_W = (NREG > 1) ? $clog2(NREG) : 1;

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_AND  = 6'd3;
  localparam logic [5:0] OP_OR   = 6'd4;
  localparam logic [5:0] OP_XOR  = 6'd5;
  localparam logic [5:0] OP_MUL  = 6'd6;
  localparam logic [5:0] OP_LDI  = 6'd7;
  localparam logic [5:0] OP_BEQ  = 6'd8;
  localparam logic [5:0] OP_HALT = 6'd63;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  state_t state, state_next;

  logic              started;
  logic [PC_W-1:0]   pc;
  logic [31:0]       ir;
  logic [DATA_W-1:0] a, b;
  logic [DATA_W-1:0] res_lo;
  logic              taken;
  logic [DATA_W-1:0] regs [NREG];

  logic [5:0]        op;
  logic [RI_W-1:0]   rd_idx, ra_idx, rb_idx;
  logic              op_known, writes_rd;
  logic [DATA_W-1:0] alu_lo;
  logic              alu_zero;
  logic [PC_W-1:0]   pc_inc, pc_br;
  logic              fetch_take;
  logic              unused_ir;

`ifdef CPU_MC_MUL_EN
  logic [RI_W-1:0]     rd2_idx;
  logic [DATA_W-1:0]   res_hi, alu_hi;
  logic [2*DATA_W-1:0] prod;
  assign rd2_idx = ir[16 +: RI_W];
`endif

  assign op     = ir[31:26];
  assign rd_idx = ir[21 +: RI_W];
  assign ra_idx = ir[11 +: RI_W];
  assign rb_idx = ir[6 +: RI_W];
  assign unused_ir = ^ir[25:16];

  assign pc_inc = pc + PC_W'(2);
  assign pc_br  = pc_inc + PC_W'({{25{ir[5]}}, ir[5:0], 1'b0});

  // Nothing is fetched until one clock edge has passed since reset released.
  assign fetch_take = (state == S_FETCH) && started && imem_valid;

  assign imem_addr = pc;
  assign pc_out    = pc;

  always_comb begin
    op_known  = 1'b1;
    writes_rd = 1'b0;
    case (op)
      OP_NOP, OP_BEQ, OP_HALT: begin
        writes_rd = 1'b0;
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LDI: begin
        writes_rd = 1'b1;
      end
`ifdef CPU_MC_MUL_EN
      OP_MUL: begin
        writes_rd = 1'b1;
      end
`endif
      default: begin
        op_known = 1'b0;
      end
    endcase
  end

  always_comb begin
    alu_lo = '0;
`ifdef CPU_MC_MUL_EN
    alu_hi = '0;
    prod   = '0;
`endif
    case (op)
      OP_ADD: alu_lo = a + b;
      OP_SUB: alu_lo = a - b;
      OP_AND: alu_lo = a & b;
      OP_OR:  alu_lo = a | b;
      OP_XOR: alu_lo = a ^ b;
      OP_LDI: alu_lo = DATA_W'({16'h0000, ir[15:0]});
`ifdef CPU_MC_MUL_EN
      OP_MUL: begin
        prod   = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        alu_lo = prod[DATA_W-1:0];
        alu_hi = prod[2*DATA_W-1:DATA_W];
      end
`endif
      default: alu_lo = '0;
    endcase
`ifdef CPU_MC_MUL_EN
    alu_zero = (alu_lo == '0) && (alu_hi == '0);
`else
    alu_zero = (alu_lo == '0);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    halted     = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = started;
        if (fetch_take) state_next = S_DECODE;
      end
      S_DECODE: state_next = S_EXEC;
      S_EXEC:   state_next = S_WB;
      S_WB: begin
        illegal    = ~op_known;
        state_next = (op == OP_HALT) ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        halted     = 1'b1;
        state_next = S_HALT;
      end
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      started <= 1'b0;
      pc      <= '0;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      res_lo  <= '0;
      taken   <= 1'b0;
      out     <= '0;
      zero    <= 1'b0;
`ifdef CPU_MC_MUL_EN
      res_hi  <= '0;
`endif
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      started <= 1'b1;
      case (state)
        S_FETCH: begin
          if (fetch_take) ir <= imem_rdata;
        end
        S_DECODE: begin
          a <= (ra_idx == '0) ? '0 : regs[ra_idx];
          b <= (rb_idx == '0) ? '0 : regs[rb_idx];
        end
        S_EXEC: begin
          res_lo <= alu_lo;
`ifdef CPU_MC_MUL_EN
          res_hi <= alu_hi;
`endif
          taken  <= (op == OP_BEQ) && (a == b);
          if (writes_rd) zero <= alu_zero;
        end
        S_WB: begin
          if (writes_rd) begin
            out <= res_lo;
            if (rd_idx != '0) regs[rd_idx] <= res_lo;
          end
`ifdef CPU_MC_MUL_EN
          // Issued after the low-half write so the high half wins when rd == rd2.
          if (op == OP_MUL && rd2_idx != '0) regs[rd2_idx] <= res_hi;
`endif
          if (op != OP_HALT) pc <= taken ? pc_br : pc_inc;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mc.sv
// tb/tb_cpu_mc.sv - directed self-checking bench for cpu_mc.
module tb_cpu_mc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [15:0] out;
  logic [5:0]  pc_out;
  logic        zero, halted, illegal;

  int checks = 0;
  int errors = 0;
  int ill_cnt;

  cpu_mc #(.DATA_W(16), .PC_W(6), .NREG(8)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .out(out), .pc_out(pc_out), .zero(zero),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rd,
                                      input logic [4:0] rd2, input logic [4:0] ra,
                                      input logic [4:0] rb, input logic [5:0] off);
    return {op, rd, rd2, ra, rb, off};
  endfunction

  function automatic logic [31:0] ldi(input logic [4:0] rd, input logic [15:0] imm);
    return {6'd7, rd, 5'd0, imm};
  endfunction

  // Enter at a negedge with reset low; leave at a negedge with the first fetch requested.
  task automatic do_reset(input string tag);
    #1 reset = 1'b1;
    #1;
    check({tag, "_pc"}, 32'(pc_out), 32'd0);
    check({tag, "_out"}, 32'(out), 32'd0);
    check({tag, "_zero"}, 32'(zero), 32'd0);
    check({tag, "_halted"}, 32'(halted), 32'd0);
    check({tag, "_illegal"}, 32'(illegal), 32'd0);
    imem_valid = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, "_req_in_reset"}, 32'(imem_req), 32'd0);
    reset = 1'b0;
    #1 check({tag, "_req_before_edge"}, 32'(imem_req), 32'd0);
    @(negedge clk);
    check({tag, "_first_req"}, 32'(imem_req), 32'd1);
    check({tag, "_first_addr"}, 32'(imem_addr), 32'd0);
  endtask

  // Fetch and retire one instruction; returns at the negedge after WB.
  task automatic issue(input string tag, input logic [31:0] instr, input logic [5:0] exp_addr,
                       input int stall, input bit noisy);
    int n;
    int stall_bad;
    n = 0;
    stall_bad = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req"}, 32'(imem_req), 32'd1);
    check({tag, "_addr"}, 32'(imem_addr), 32'(exp_addr));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (!imem_req || pc_out != exp_addr || halted) stall_bad++;
    end
    if (stall > 0) check({tag, "_stall"}, 32'(stall_bad), 32'd0);
    imem_valid = 1'b1;
    imem_rdata = instr;
    ill_cnt = 0;
    @(negedge clk);
    if (noisy) imem_rdata = 32'hFC00_0000;
    else imem_valid = 1'b0;
    if (illegal) ill_cnt++;
    @(negedge clk);
    if (illegal) ill_cnt++;
    @(negedge clk);
    if (illegal) ill_cnt++;
    imem_valid = 1'b0;
    @(negedge clk);
    if (illegal) ill_cnt++;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_pc", 32'(pc_out), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    reset = 1'b0;
    #1 check("rst_req_before_edge", 32'(imem_req), 32'd0);
    @(negedge clk);
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", 32'(imem_addr), 32'd0);

    issue("ldi1", ldi(5'd1, 16'h0005), 6'd0, 0, 1'b0);
    check("ldi1_out", 32'(out), 32'h0005);
    issue("ldi2", ldi(5'd2, 16'h0003), 6'd2, 0, 1'b0);
    check("ldi2_out", 32'(out), 32'h0003);
    issue("add", enc(6'd1, 5'd3, 5'd0, 5'd1, 5'd2, 6'd0), 6'd4, 0, 1'b0);
    check("add_out", 32'(out), 32'h0008);
    check("add_zero", 32'(zero), 32'd0);
    check("add_pc", 32'(pc_out), 32'd6);
    check("add_ill", 32'(ill_cnt), 32'd0);

    issue("sub0", enc(6'd2, 5'd4, 5'd0, 5'd1, 5'd1, 6'd0), 6'd6, 0, 1'b0);
    check("sub0_out", 32'(out), 32'h0000);
    check("sub0_zero", 32'(zero), 32'd1);
    issue("beq_t", enc(6'd8, 5'd0, 5'd0, 5'd1, 5'd1, 6'h3E), 6'd8, 0, 1'b0);
    check("beq_t_pc", 32'(pc_out), 32'd6);
    check("beq_t_zero", 32'(zero), 32'd1);
    issue("subn", enc(6'd2, 5'd5, 5'd0, 5'd2, 5'd1, 6'd0), 6'd6, 0, 1'b0);
    check("subn_out", 32'(out), 32'hFFFE);
    check("subn_zero", 32'(zero), 32'd0);
    issue("beq_n", enc(6'd8, 5'd0, 5'd0, 5'd1, 5'd2, 6'h3E), 6'd8, 0, 1'b0);
    check("beq_n_pc", 32'(pc_out), 32'd10);

    issue("undef", {6'h2A, 26'h0}, 6'd10, 5, 1'b0);
    check("undef_ill_cycles", 32'(ill_cnt), 32'd1);
    check("undef_pc", 32'(pc_out), 32'd12);
    check("undef_out", 32'(out), 32'hFFFE);

    issue("ldi3", ldi(5'd1, 16'h1234), 6'd12, 0, 1'b0);
    issue("ldi4", ldi(5'd2, 16'h0100), 6'd14, 0, 1'b0);
    issue("mul", enc(6'd6, 5'd6, 5'd7, 5'd1, 5'd2, 6'd0), 6'd16, 0, 1'b0);
`ifdef CPU_MC_MUL_EN
    check("mul_out", 32'(out), 32'h3400);
    check("mul_ill", 32'(ill_cnt), 32'd0);
    issue("rd_r6", enc(6'd1, 5'd5, 5'd0, 5'd6, 5'd0, 6'd0), 6'd18, 0, 1'b0);
    check("r6", 32'(out), 32'h3400);
    issue("rd_r7", enc(6'd1, 5'd5, 5'd0, 5'd7, 5'd0, 6'd0), 6'd20, 0, 1'b0);
    check("r7", 32'(out), 32'h0012);
`else
    check("mul_out", 32'(out), 32'h0100);
    check("mul_ill", 32'(ill_cnt), 32'd1);
    issue("rd_r6", enc(6'd1, 5'd5, 5'd0, 5'd6, 5'd0, 6'd0), 6'd18, 0, 1'b0);
    check("r6", 32'(out), 32'h0000);
    issue("rd_r7", enc(6'd1, 5'd5, 5'd0, 5'd7, 5'd0, 6'd0), 6'd20, 0, 1'b0);
    check("r7", 32'(out), 32'h0000);
`endif

    issue("jump62", enc(6'd8, 5'd0, 5'd0, 5'd0, 5'd0, 6'd19), 6'd22, 0, 1'b0);
    check("jump62_pc", 32'(pc_out), 32'd62);
    issue("wrap", 32'h0000_0000, 6'd62, 0, 1'b1);
    check("wrap_pc", 32'(pc_out), 32'd0);
    check("noise_halted", 32'(halted), 32'd0);

    issue("r0src", enc(6'd1, 5'd5, 5'd0, 5'd0, 5'd0, 6'd0), 6'd0, 0, 1'b0);
    check("r0src_out", 32'(out), 32'h0000);
    check("r0src_zero", 32'(zero), 32'd1);
    issue("r0dst", enc(6'd1, 5'd0, 5'd0, 5'd1, 5'd2, 6'd0), 6'd2, 0, 1'b0);
    check("r0dst_out", 32'(out), 32'h1334);
    issue("r0chk", enc(6'd1, 5'd5, 5'd0, 5'd0, 5'd0, 6'd0), 6'd4, 0, 1'b0);
    check("r0chk_out", 32'(out), 32'h0000);

    issue("halt", 32'hFC00_0000, 6'd6, 0, 1'b0);
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_pc", 32'(pc_out), 32'd6);
    check("halt_req", 32'(imem_req), 32'd0);
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
        imem_valid = i[0];
        imem_rdata = ldi(5'd1, 16'h00FF);
        @(negedge clk);
        if (!halted || imem_req || pc_out != 6'd6 || out != 16'h0000) bad++;
      end
      imem_valid = 1'b0;
      check("halt_frozen", 32'(bad), 32'd0);
    end

    do_reset("rst_halt");

    issue("p_ldi", ldi(5'd1, 16'h0005), 6'd0, 0, 1'b0);
    issue("p_sub", enc(6'd2, 5'd2, 5'd0, 5'd1, 5'd1, 6'd0), 6'd2, 0, 1'b0);
    check("p_sub_zero", 32'(zero), 32'd1);
    check("p_sub_pc", 32'(pc_out), 32'd4);
    imem_valid = 1'b1;
    imem_rdata = enc(6'd1, 5'd3, 5'd0, 5'd1, 5'd1, 6'd0);
    @(negedge clk);
    imem_valid = 1'b0;
    @(negedge clk);
    do_reset("rst_exec");

    issue("post", enc(6'd1, 5'd5, 5'd0, 5'd1, 5'd0, 6'd0), 6'd0, 0, 1'b0);
    check("post_regs_cleared", 32'(out), 32'h0000);
    check("post_pc", 32'(pc_out), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
